// File: rtl/mdio_responder.sv
// mdio_responder: Clause 22 MDIO target serving a 32 x 16-bit register file at one PHY address.
// Define MDIO_PREAMBLE_SUPPRESS_EN to accept a shortened preamble once one frame has been served.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR     = 5'd3,
  parameter int         PREAMBLE_LEN = 32,
  parameter logic [4:0] RO_REG       = 5'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mdc_pin,
  inout  wire         mdio_pin,
  input  logic [15:0] status_in,
  output logic        reg_wr_valid,
  output logic [4:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data,
  output logic        busy
);
  localparam int PW = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_LEN);
  typedef enum logic [3:0] {IDLE, ST, OP, PHYAD, REGAD, TA, RD_DATA, WR_DATA, SKIP} state_t;
  state_t state_q, state_d;
  logic [2:0] mdc_q;
  logic [1:0] mdio_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [4:0] cnt_q, cnt_d, addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [15:0] sr_q, sr_d, wr_data_q, wr_data_d;
  logic op_rd_q, op_rd_d, match_q, match_d, busy_q, busy_d, oe_q, oe_d, out_q, out_d;
  logic valid_q, valid_d, seen_q, seen_d;
  logic rise, fall, b, pre_ok, commit;
  logic [4:0] rd_addr;
  logic [15:0] regs_q [32];
  assign rise = mdc_q[1] & ~mdc_q[2];
  assign fall = ~mdc_q[1] & mdc_q[2];
  assign b = mdio_q[1];
  assign rd_addr = {sr_q[3:0], b};
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign pre_ok = seen_q ? pre_q != '0 : pre_q >= PRE_MAX;
`else
  assign pre_ok = pre_q >= PRE_MAX;
`endif
  always_comb begin
    state_d = state_q;
    pre_d = pre_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    sr_d = sr_q;
    op_rd_d = op_rd_q;
    match_d = match_q;
    busy_d = busy_q;
    oe_d = oe_q;
    out_d = out_q;
    seen_d = seen_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    valid_d = 1'b0;
    commit = 1'b0;
    case (state_q)
      IDLE: if (rise) begin
        pre_d = b ? (pre_q == PRE_MAX ? pre_q : pre_q + 1'b1) : '0;
        if (!b && pre_ok) begin
          state_d = ST;
          busy_d = 1'b1;
        end
      end
      ST: if (rise) begin
        state_d = b ? OP : IDLE;
        busy_d = b;
        cnt_d = '0;
      end
      OP: if (rise) begin
        sr_d = {sr_q[14:0], b};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd1) begin
          op_rd_d = sr_q[0] & ~b;
          cnt_d = '0;
          state_d = (sr_q[0] ^ b) ? PHYAD : IDLE;
          busy_d = sr_q[0] ^ b;
        end
      end
      PHYAD: if (rise) begin
        sr_d = {sr_q[14:0], b};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd4) begin
          match_d = rd_addr == PHY_ADDR;
          cnt_d = '0;
          state_d = REGAD;
        end
      end
      REGAD: if (rise) begin
        sr_d = {sr_q[14:0], b};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd4) begin
          addr_d = rd_addr;
          cnt_d = '0;
          state_d = match_q ? TA : SKIP;
          if (op_rd_q) sr_d = rd_addr == RO_REG ? status_in : regs_q[rd_addr];
        end
      end
      TA: if (op_rd_q ? fall : rise) begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd1) begin
          cnt_d = '0;
          state_d = op_rd_q ? RD_DATA : WR_DATA;
          oe_d = op_rd_q;
          out_d = 1'b0;
        end
      end
      RD_DATA: if (fall) begin
        if (cnt_q == 5'd16) begin
          oe_d = 1'b0;
          state_d = IDLE;
          busy_d = 1'b0;
          seen_d = 1'b1;
        end else begin
          out_d = sr_q[15];
          sr_d = {sr_q[14:0], 1'b0};
          cnt_d = cnt_q + 5'd1;
        end
      end
      WR_DATA: if (rise) begin
        sr_d = {sr_q[14:0], b};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          state_d = IDLE;
          busy_d = 1'b0;
          seen_d = 1'b1;
          if (addr_q != RO_REG) begin
            commit = 1'b1;
            valid_d = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = {sr_q[14:0], b};
          end
        end
      end
      SKIP: if (rise) begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd17) begin
          state_d = IDLE;
          busy_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d = 1'b0;
        oe_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mdc_q <= '0;
      mdio_q <= '0;
      state_q <= IDLE;
      pre_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      sr_q <= '0;
      op_rd_q <= 1'b0;
      match_q <= 1'b0;
      busy_q <= 1'b0;
      oe_q <= 1'b0;
      out_q <= 1'b0;
      seen_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      mdc_q <= {mdc_q[1:0], mdc_pin};
      mdio_q <= {mdio_q[0], mdio_pin};
      state_q <= state_d;
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      sr_q <= sr_d;
      op_rd_q <= op_rd_d;
      match_q <= match_d;
      busy_q <= busy_d;
      oe_q <= oe_d;
      out_q <= out_d;
      seen_q <= seen_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      valid_q <= valid_d;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (commit) begin
      regs_q[addr_q] <= wr_data_d;
    end
  end
  assign mdio_pin = oe_q ? out_q : 1'bz;
  assign busy = busy_q;
  assign reg_wr_valid = valid_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: directed MDIO master frames against mdio_responder with hand-computed expectations.
module tb_mdio_responder;
  logic clock = 1'b0, reset = 1'b1, mdc = 1'b0, tb_oe = 1'b0, tb_do = 1'b0;
  logic [15:0] status_in = 16'h0000;
  logic reg_wr_valid, busy;
  logic [4:0] reg_wr_addr;
  logic [15:0] reg_wr_data;
  wire mdio_w;
  int n_tot = 0, n_bad = 0, npulse = 0;
  logic [4:0] cap_addr = '0;
  logic [15:0] cap_data = '0;
  logic [15:0] d;
  logic ta1, ta2, rel, bm;

  assign mdio_w = tb_oe ? tb_do : 1'bz;
  pullup (mdio_w);

  mdio_responder dut (
    .clock(clock), .reset(reset), .mdc_pin(mdc), .mdio_pin(mdio_w), .status_in(status_in),
    .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (reg_wr_valid) begin
    npulse <= npulse + 1;
    cap_addr <= reg_wr_addr;
    cap_data <= reg_wr_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One MDC period: data set up 40 ns before the rise, pin sampled just before the rise.
  task automatic slot(input logic drv, input logic val, output logic smp);
    tb_oe = drv;
    tb_do = val;
    #40;
    smp = mdio_w;
    mdc = 1'b1;
    #80;
    mdc = 1'b0;
    #40;
  endtask

  task automatic header(input int npre, input logic rd, input logic [4:0] phy, input logic [4:0] rg);
    logic s;
    for (int i = 0; i < npre; i++) slot(1'b1, 1'b1, s);
    slot(1'b1, 1'b0, s);
    slot(1'b1, 1'b1, s);
    slot(1'b1, rd, s);
    slot(1'b1, ~rd, s);
    for (int i = 4; i >= 0; i--) slot(1'b1, phy[i], s);
    for (int i = 4; i >= 0; i--) slot(1'b1, rg[i], s);
  endtask

  task automatic wr_frame(input int npre, input logic [4:0] phy, input logic [4:0] rg,
                          input logic [15:0] wd, output logic bmid);
    logic s;
    header(npre, 1'b0, phy, rg);
    slot(1'b1, 1'b1, s);
    slot(1'b1, 1'b0, s);
    bmid = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      slot(1'b1, wd[i], s);
      if (i == 8) bmid = busy;
    end
    tb_oe = 1'b0;
  endtask

  task automatic rd_frame(input int npre, input logic [4:0] phy, input logic [4:0] rg, input int nd,
                          output logic [15:0] rdat, output logic t1, output logic t2,
                          output logic rl, output logic bmid);
    logic s;
    header(npre, 1'b1, phy, rg);
    slot(1'b0, 1'b0, t1);
    slot(1'b0, 1'b0, t2);
    rdat = '0;
    bmid = 1'b0;
    rl = 1'b1;
    for (int i = 0; i < nd; i++) begin
      slot(1'b0, 1'b0, s);
      rdat = {rdat[14:0], s};
      if (i == 8) bmid = busy;
    end
    if (nd == 16) slot(1'b0, 1'b0, rl);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #102;
    check("rst_busy", busy, 0);
    check("rst_valid", reg_wr_valid, 0);
    check("rst_addr", reg_wr_addr, 0);
    check("rst_data", reg_wr_data, 0);
    check("rst_pin", mdio_w, 1);
    reset = 1'b0;
    #20;
    wr_frame(31, 5'd3, 5'd4, 16'h0BAD, bm);
    check("pre31_nopulse", npulse, 0);
    check("idle_busy", busy, 0);
    wr_frame(32, 5'd3, 5'd4, 16'h01E1, bm);
    check("wr_busy_mid", bm, 1);
    check("wr_busy_end", busy, 0);
    check("wr_pulses", npulse, 1);
    check("wr_addr", cap_addr, 4);
    check("wr_data", cap_data, 16'h01E1);
    check("wr_data_out", reg_wr_data, 16'h01E1);
    rd_frame(32, 5'd3, 5'd4, 16, d, ta1, ta2, rel, bm);
    check("rd4_ta1", ta1, 1);
    check("rd4_ta2", ta2, 0);
    check("rd4_data", d, 16'h01E1);
    check("rd4_release", rel, 1);
    check("rd4_busy_mid", bm, 1);
    check("rd4_busy_end", busy, 0);
    status_in = 16'h782D;
    rd_frame(32, 5'd3, 5'd1, 16, d, ta1, ta2, rel, bm);
    check("ro_rd", d, 16'h782D);
    wr_frame(32, 5'd3, 5'd1, 16'hFFFF, bm);
    check("ro_wr_nopulse", npulse, 1);
    rd_frame(32, 5'd3, 5'd1, 16, d, ta1, ta2, rel, bm);
    check("ro_rd_again", d, 16'h782D);
    wr_frame(32, 5'd5, 5'd6, 16'h1111, bm);
    check("phy5_wr_nopulse", npulse, 1);
    rd_frame(32, 5'd5, 5'd4, 16, d, ta1, ta2, rel, bm);
    check("phy5_rd_ta2", ta2, 1);
    check("phy5_rd_data", d, 16'hFFFF);
    wr_frame(32, 5'd3, 5'd7, 16'h5A5A, bm);
    check("after_skip_pulses", npulse, 2);
    check("after_skip_addr", cap_addr, 7);
    check("after_skip_data", cap_data, 16'h5A5A);
    rd_frame(32, 5'd3, 5'd4, 16, d, ta1, ta2, rel, bm);
    check("rd4_kept", d, 16'h01E1);
    rd_frame(32, 5'd3, 5'd7, 7, d, ta1, ta2, rel, bm);
    check("rd7_partial", d, 16'h002D);
    tb_oe = 1'b0;
    #40;
    check("rd7_bit8", mdio_w, 0);
    reset = 1'b1;
    #1;
    check("midrst_pin", mdio_w, 1);
    check("midrst_busy", busy, 0);
    check("midrst_valid", reg_wr_valid, 0);
    check("midrst_addr", reg_wr_addr, 0);
    check("midrst_data", reg_wr_data, 0);
    #39;
    reset = 1'b0;
    #100;
    rd_frame(32, 5'd3, 5'd7, 16, d, ta1, ta2, rel, bm);
    check("clr_rd7", d, 16'h0000);
    check("clr_rd7_ta2", ta2, 0);
    rd_frame(32, 5'd3, 5'd4, 16, d, ta1, ta2, rel, bm);
    check("clr_rd4", d, 16'h0000);
    wr_frame(32, 5'd3, 5'd9, 16'h1234, bm);
    check("wr9_pulses", npulse, 3);
    rd_frame(1, 5'd3, 5'd9, 16, d, ta1, ta2, rel, bm);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    check("short_pre_data", d, 16'h1234);
    check("short_pre_ta2", ta2, 0);
`else
    check("short_pre_data", d, 16'hFFFF);
    check("short_pre_ta2", ta2, 1);
`endif
    check("final_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/mdio_responder.md
Name: mdio_responder

Overview:
- PHY-side MDIO management target (Clause 22); the responder end of the FPGA's MDIO master.
- Decodes MDC/MDIO frames addressed to one PHY address and serves a 32 x 16-bit register file.
- Reports register writes to local logic and returns a live status word at register 1.
- Used for loopback test of the management path and for emulating a PHY toward an external MAC.

Parameters:
- PHY_ADDR, 5'd3, PHY address this block answers to.
- PREAMBLE_LEN, 32, consecutive ones required before ST.
- RO_REG, 5'd1, read-only register index; reads return status_in.

Ports:
- clock  input  1  system clock; must be >= 8x MDC frequency.
- reset  input  1  asynchronous, active-high.
- mdc_pin  input  1  management clock from master; asynchronous to clock.
- mdio_pin  inout  1  management data; driven only during read TA2/data, else high-Z.
- status_in  input  16  value returned for reads of RO_REG.
- reg_wr_valid  output  1  one-clock pulse when a write commits.
- reg_wr_addr  output  5  register index of committed write.
- reg_wr_data  output  16  data of committed write.
- busy  output  1  high from valid ST until frame end.

Behaviour:
- Sampling:
  - mdc_pin and mdio_pin pass through 2-flop synchronisers.
  - MDC rise = sample event; MDC fall = drive event; both detected from synchronised MDC.
  - Bits are sampled on MDC rise; responder-driven bits change on MDC fall.
- States: IDLE, ST, OP, PHYAD, REGAD, TA, RD_DATA, WR_DATA, SKIP.
- IDLE:
  - Saturating preamble counter increments on each sampled 1; clears on a sampled 0.
  - A 0 sampled with counter >= PREAMBLE_LEN goes to ST.
  - A 0 with counter < PREAMBLE_LEN stays in IDLE.
- ST:
  - Next bit must be 1, otherwise IDLE.
  - busy goes high on entry to ST.
- OP:
  - 2 bits. 10 = read, 01 = write.
  - 00 or 11 -> IDLE and busy low; a new preamble is then required.
- PHYAD:
  - 5 bits, MSB first.
  - Mismatch with PHY_ADDR -> SKIP after REGAD. SKIP counts 18 sample events (TA + 16 data), then IDLE; pin never driven.
- REGAD:
  - 5 bits, MSB first.
  - On read, the 16-bit shift register loads at the 5th sample: status_in if addr == RO_REG, else regfile[addr].
- TA, read:
  - Stay high-Z through the first MDC fall after REGAD (TA1).
  - On the next MDC fall drive 0 (TA2).
- TA, write: two bits sampled and ignored.
- RD_DATA:
  - 16 MDC falls each drive the next bit, MSB first.
  - On the MDC fall after bit 0: release to high-Z, then IDLE.
- WR_DATA:
  - 16 samples shifted MSB first.
  - At the 16th sample: regfile[addr] <= data unless addr == RO_REG.
  - On commit, reg_wr_valid pulses for 1 clock with reg_wr_addr/reg_wr_data valid; then IDLE.
  - Writes to RO_REG are discarded with no pulse.
- After any frame, the preamble counter restarts at 0.
- Reset, asserted at any time including mid-frame:
  - Immediate high-Z on mdio_pin; state IDLE; busy = 0; reg_wr_valid = 0; reg_wr_addr = 0; reg_wr_data = 0.
  - Preamble counter = 0; all regfile entries = 16'h0000.
- Latency: drive change appears <= 4 clocks after the MDC falling edge at the pin, within half an MDC period at the 8x ratio.

Optional Feature:
- Macro: MDIO_PREAMBLE_SUPPRESS_EN.
- Defined: after the first qualifying frame, a later ST is accepted with >= 1 idle one preceding it (preamble suppression, BMSR bit 6 style).
- Not defined: every frame needs PREAMBLE_LEN ones.

Test Plan:
- 32 ones, write frame PHYAD 3, REGAD 4, data 0x01E1 -> single reg_wr_valid pulse, reg_wr_addr = 4, reg_wr_data = 0x01E1; busy high from ST to last bit.
- Same then read REGAD 4 -> TA1 high-Z, TA2 = 0, data bits 0x01E1 MSB first, high-Z after bit 0.
- status_in = 0x782D, read REGAD 1 -> returns 0x782D; write 0xFFFF to REGAD 1 -> no pulse, next read still 0x782D.
- Write to PHYAD 5 -> no pulse, pin high-Z throughout; next valid frame to PHYAD 3 succeeds.
- 31-one preamble then write frame -> ignored, no pulse; reset asserted during RD_DATA bit 8 -> pin high-Z immediately, busy = 0, regfile cleared.
- With MDIO_PREAMBLE_SUPPRESS_EN: valid frame, then 1 one + read frame -> served; without macro -> ignored.
